// File: rtl/arb_pkg.sv
// Shared constants, state codes and round-robin search helper for bus_arbiter_8.
package arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;
  localparam logic [NREQ-1:0] NO_GNT = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Returns {found, idx}: first low request bit at or above ptr, wrapping 7->0.
  function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0] req_n,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    // Scan from farthest to nearest so the nearest hit overwrites the rest.
    for (int unsigned k = NREQ; k > 0; k--) begin
      idx = ptr + SEL_W'(k - 1);
      if (!req_n[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/gnt_decode.sv
// 3-to-8 active-low one-hot decoder; all outputs high when disabled.
module gnt_decode
  import arb_pkg::*;
(
  input  logic [SEL_W-1:0] idx,
  input  logic             en,
  output logic [NREQ-1:0]  gnt_n
);

  always_comb begin
    gnt_n = NO_GNT;
    if (en) gnt_n[idx] = 1'b0;
  end

endmodule

// File: rtl/bus_arbiter_8.sv
// 8-way round-robin bus arbiter with registered active-low grants and turnaround gap.
// Optional grant-length limit enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_8
  import arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_n,
  output logic [7:0] gnt_n,
  output logic [2:0] gnt_sel,
  output logic       busy,
  output logic       timeout
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 7 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("bus_arbiter_8: GAP_CYCLES or TIMEOUT_CYCLES out of range");
  end

  logic [1:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [2:0]       gap_cnt;
  logic [SEL_W:0]   pick;
  logic             dec_en;
  logic [NREQ-1:0]  dec_gnt_n;
  logic             held;
  logic             to_hit;
  logic             revoke;

  always_comb begin
    pick   = rr_pick(req_n, ptr);
    dec_en = (state == ST_IDLE) && pick[SEL_W];
  end

  gnt_decode u_gnt_decode (
    .idx   (pick[SEL_W-1:0]),
    .en    (dec_en),
    .gnt_n (dec_gnt_n)
  );

  assign held   = ~req_n[gnt_sel];
  assign revoke = (state == ST_GRANT) && (!held || to_hit);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;

  // cnt holds the number of completed GRANT cycles before the current edge.
  assign to_hit = held && (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state == ST_GRANT) && to_hit;
      if (state == ST_GRANT) cnt <= cnt + 8'd1;
      else                   cnt <= '0;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt_sel <= '0;
      gnt_n   <= NO_GNT;
      busy    <= 1'b0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick[SEL_W]) begin
            state   <= ST_GRANT;
            gnt_sel <= pick[SEL_W-1:0];
            gnt_n   <= dec_gnt_n;
            busy    <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (revoke) begin
            state   <= ST_TURN;
            gnt_n   <= NO_GNT;
            busy    <= 1'b0;
            ptr     <= gnt_sel + SEL_W'(1);
            gap_cnt <= '0;
          end
        end
        ST_TURN: begin
          if (gap_cnt == 3'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else                               gap_cnt <= gap_cnt + 3'd1;
        end
        default: begin
          state <= ST_IDLE;
          gnt_n <= NO_GNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Self-checking bench for bus_arbiter_8: expected grant indices are queued when requests are driven.
module tb_bus_arbiter_8;

  localparam int GAP_A = 1;
  localparam int GAP_B = 3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] req_n  = 8'hFF;
  logic [7:0] req3_n = 8'hFF;

  logic [7:0] gnt_n, g3_n;
  logic [2:0] gnt_sel, s3;
  logic       busy, b3, timeout, t3;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp3_q[$];

  always #5 clk = ~clk;

  bus_arbiter_8 #(.GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n),
    .gnt_n(gnt_n), .gnt_sel(gnt_sel), .busy(busy), .timeout(timeout)
  );

  bus_arbiter_8 #(.GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(16)) u_gap3 (
    .clk(clk), .rst_n(rst_n), .req_n(req3_n),
    .gnt_n(g3_n), .gnt_sel(s3), .busy(b3), .timeout(t3)
  );

  // Waits (bounded) on negedges for busy to reach level; n counts negedges waited.
  task automatic wait_busy(input bit inst3, input logic level, input int max,
                           output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max) begin
      @(negedge clk);
      n++;
      if ((inst3 ? b3 : busy) === level) ok = 1'b1;
    end
  endtask

  task automatic go_idle;
    req_n  = 8'hFF;
    req3_n = 8'hFF;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (gnt_n !== 8'hFF) begin errors++; $display("FAIL reset_gnt_n: got %h want ff", gnt_n); end
    checks++; if (gnt_sel !== 3'd0) begin errors++; $display("FAIL reset_gnt_sel: got %0d want 0", gnt_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (g3_n !== 8'hFF || b3 !== 1'b0) begin errors++; $display("FAIL reset_gap3: got gnt_n %h busy %b want ff 0", g3_n, b3); end
    rst_n = 1'b1;
  endtask

  task automatic test_fairness;
    bit ok; int n, e; logic [7:0] eg;
    req_n = 8'h00;
    for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
    for (int g = 0; g < 9; g++) begin
      wait_busy(1'b0, 1'b1, 8, ok, n);
      checks++;
      if (!ok) begin errors++; $display("FAIL fair_grant%0d: no grant within %0d cycles", g, n); break; end
      if (g > 0) begin
        checks++;
        if (n !== GAP_A + 1) begin errors++; $display("FAIL fair_gap%0d: got %0d idle cycles want %0d", g, n, GAP_A + 1); end
      end
      e  = exp_q.pop_front();
      eg = ~(8'h01 << e);
      checks++; if (gnt_sel !== 3'(e)) begin errors++; $display("FAIL fair_sel%0d: got %0d want %0d", g, gnt_sel, e); end
      checks++; if (gnt_n !== eg) begin errors++; $display("FAIL fair_gnt_n%0d: got %h want %h", g, gnt_n, eg); end
      @(negedge clk);
      req_n = 8'h01 << e;
      @(negedge clk);
      checks++; if (gnt_n !== 8'hFF || busy !== 1'b0) begin errors++; $display("FAIL fair_release%0d: got gnt_n %h busy %b want ff 0", g, gnt_n, busy); end
      req_n = 8'h00;
    end
    exp_q.delete();
    go_idle();
  endtask

  task automatic test_single;
    bit ok; int n, e; logic [7:0] eg;
    @(negedge clk);
    req_n = 8'hFB;
    exp_q.push_back(2);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    checks++; if (!ok || n !== 1) begin errors++; $display("FAIL single_latency: got ok %b after %0d cycles want 1", ok, n); end
    e  = exp_q.pop_front();
    eg = ~(8'h01 << e);
    checks++; if (gnt_sel !== 3'(e)) begin errors++; $display("FAIL single_sel: got %0d want %0d", gnt_sel, e); end
    checks++; if (gnt_n !== eg) begin errors++; $display("FAIL single_gnt_n: got %h want %h", gnt_n, eg); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (gnt_n !== eg) begin errors++; $display("FAIL single_hold: got %h want %h", gnt_n, eg); end
    req_n = 8'hFF;
    @(negedge clk);
    checks++; if (gnt_n !== 8'hFF || busy !== 1'b0) begin errors++; $display("FAIL single_release: got gnt_n %h busy %b want ff 0", gnt_n, busy); end
    // Pointer should now be 3: with everyone requesting, 3 wins.
    req_n = 8'h00;
    exp_q.push_back(3);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    checks++; if (!ok || n !== GAP_A + 1) begin errors++; $display("FAIL single_turn: got ok %b after %0d cycles want %0d", ok, n, GAP_A + 1); end
    e = exp_q.pop_front();
    checks++; if (gnt_sel !== 3'(e)) begin errors++; $display("FAIL single_ptr: got %0d want %0d", gnt_sel, e); end
    go_idle();
  endtask

  task automatic test_wrap;
    bit ok; int n, e;
    req_n = 8'hBF;
    exp_q.push_back(6);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    e = exp_q.pop_front();
    checks++; if (!ok || gnt_sel !== 3'(e)) begin errors++; $display("FAIL wrap_setup: got ok %b sel %0d want %0d", ok, gnt_sel, e); end
    go_idle();
    req_n = 8'h7E;
    exp_q.push_back(7);
    exp_q.push_back(0);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    e = exp_q.pop_front();
    checks++; if (!ok || gnt_sel !== 3'(e) || gnt_n !== 8'h7F) begin errors++; $display("FAIL wrap_first: got sel %0d gnt_n %h want %0d 7f", gnt_sel, gnt_n, e); end
    req_n = 8'hFE;
    wait_busy(1'b0, 1'b0, 8, ok, n);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    e = exp_q.pop_front();
    checks++; if (!ok || gnt_sel !== 3'(e) || gnt_n !== 8'hFE) begin errors++; $display("FAIL wrap_second: got sel %0d gnt_n %h want %0d fe", gnt_sel, gnt_n, e); end
    go_idle();
  endtask

  task automatic test_mid_reset;
    bit ok; int n, e;
    req_n = 8'hDF;
    exp_q.push_back(5);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    e = exp_q.pop_front();
    checks++; if (!ok || gnt_sel !== 3'(e) || gnt_n !== 8'hDF) begin errors++; $display("FAIL midrst_grant: got sel %0d gnt_n %h want %0d df", gnt_sel, gnt_n, e); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt_n !== 8'hFF || busy !== 1'b0 || gnt_sel !== 3'd0) begin errors++; $display("FAIL midrst_async: got gnt_n %h busy %b sel %0d want ff 0 0", gnt_n, busy, gnt_sel); end
    @(negedge clk);
    rst_n = 1'b1;
    req_n = 8'h00;
    exp_q.push_back(0);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    e = exp_q.pop_front();
    checks++; if (!ok || n !== 1 || gnt_sel !== 3'(e)) begin errors++; $display("FAIL midrst_after: got ok %b cycles %0d sel %0d want 1 %0d", ok, n, gnt_sel, e); end
    go_idle();
  endtask

  task automatic test_timeout;
    bit ok; int n, e;
    req_n = 8'hEF;
    exp_q.push_back(4);
    wait_busy(1'b0, 1'b1, 8, ok, n);
    e = exp_q.pop_front();
    checks++; if (!ok || gnt_sel !== 3'(e)) begin errors++; $display("FAIL to_grant: got ok %b sel %0d want %0d", ok, gnt_sel, e); end
`ifdef ARB_TIMEOUT_EN
    begin
      int held = 1;
      bit early = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (busy !== 1'b1) break;
        if (timeout !== 1'b0) early = 1'b1;
        held++;
      end
      checks++; if (held !== 16) begin errors++; $display("FAIL to_length: got %0d cycles want 16", held); end
      checks++; if (timeout !== 1'b1 || gnt_n !== 8'hFF || early) begin errors++; $display("FAIL to_pulse: got timeout %b gnt_n %h early %b want 1 ff 0", timeout, gnt_n, early); end
      req_n = 8'hCF;
      exp_q.push_back(5);
      @(negedge clk);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_width: got %b want 0", timeout); end
      wait_busy(1'b0, 1'b1, 8, ok, n);
      e = exp_q.pop_front();
      checks++; if (!ok || gnt_sel !== 3'(e)) begin errors++; $display("FAIL to_ptr: got ok %b sel %0d want %0d", ok, gnt_sel, e); end
    end
`else
    begin
      bit bad = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (busy !== 1'b1 || timeout !== 1'b0 || gnt_n !== 8'hEF) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL to_persist: got busy %b timeout %b gnt_n %h want 1 0 ef", busy, timeout, gnt_n); end
    end
`endif
    go_idle();
  endtask

  task automatic test_gap3;
    bit ok; int n, e;
    req3_n = 8'h00;
    for (int i = 0; i < 3; i++) exp3_q.push_back(i);
    for (int g = 0; g < 3; g++) begin
      wait_busy(1'b1, 1'b1, 12, ok, n);
      checks++;
      if (!ok) begin errors++; $display("FAIL gap3_grant%0d: no grant within %0d cycles", g, n); break; end
      if (g > 0) begin
        checks++;
        if (n !== GAP_B + 1) begin errors++; $display("FAIL gap3_len%0d: got %0d idle cycles want %0d", g, n, GAP_B + 1); end
      end
      e = exp3_q.pop_front();
      checks++; if (s3 !== 3'(e) || g3_n !== 8'(~(8'h01 << e))) begin errors++; $display("FAIL gap3_sel%0d: got sel %0d gnt_n %h want %0d", g, s3, g3_n, e); end
      req3_n = 8'h01 << e;
      @(negedge clk);
      checks++; if (g3_n !== 8'hFF) begin errors++; $display("FAIL gap3_release%0d: got %h want ff", g, g3_n); end
      req3_n = 8'h00;
    end
    exp3_q.delete();
    go_idle();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_wrap();
    test_mid_reset();
    test_timeout();
    test_gap3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
